i8254_bus_ctrl: RTL and testbench
=================================

# i8254_bus_ctrl

Bus-interface and command sequencer for the three-counter 8254 timer. Decodes CPU read/write strobes on the 2-bit address into per-counter control-word loads, LSB/MSB count-byte sequencing, counter-latch commands and byte-ordered readback. It sits between the system bus and the three counter instances, driving each counter's `controlWord`, `countIn` and `dataEn`, and sampling each counter's live count.

## Interface
- `CNT_W`, 16: count width per counter; byte sequencing covers bits `[15:0]`.
- `clk` in 1: single clock. All strobes are sampled on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cs_n` in 1: chip select, active low.
- `rd_n` in 1: read strobe, active low.
- `wr_n` in 1: write strobe, active low.
- `a` in 2: register select. 0/1/2 select counter 0/1/2; 3 selects the control register.
- `din` in 8: write data bus.
- `dout` out 8: read data.
- `dout_en` out 1: read data valid / bus drive enable.
- `cw0`, `cw1`, `cw2` out 6 each: control words as `{RW[1:0], M[2:0], BCD}`.
- `cw_load` out 3: one-cycle pulse per counter when its control word changes.
- `count_byte` out 8: count byte being written.
- `count_hi` out 1: 1 means `count_byte` is the MSB.
- `count_wr` out 3: one-cycle pulse per counter qualifying `count_byte`.
- `cnt_val` in 48: live counts, `{c2,c1,c0}`, 16 bits each.

## Operation
- **Write capture.** While `cs_n=0` and `wr_n=0`, `din` and `a` are registered every cycle.
  - The write event fires on the first edge where `wr_n=1` and the previous sample was 0 with `cs_n` low.
  - The event uses the last captured `din`/`a`.
- **Control write (`a=3`).** `SC=din[7:6]`, `RW=din[5:4]`.
  - `SC=3`: no-op. Read-back is not supported.
  - `RW=00`: counter-latch command for counter SC.
    - If not already latched, copy `cnt_val[SC]` into `latch[SC]` and set `latched[SC]`.
    - If already latched, ignore the command (the first latch wins).
    - `cw` is unchanged.
  - `RW!=00`:
    - `cwSC <= din[5:0]` and pulse `cw_load[SC]`.
    - Reset `wptr[SC]` and `rptr[SC]` to LSB.
    - Clear `latched[SC]`.
- **Count write (`a=n`, n=0..2).** Pulse `count_wr[n]` with `count_byte=din`. `count_hi` follows `RW` of `cw_n`:
  - `01`: `count_hi=0`.
  - `10`: `count_hi=1`.
  - `11`: `count_hi=wptr[n]`, then `wptr[n]` toggles.
  - `00` (unprogrammed since reset): the write is ignored and no pulse is issued.
- **Read.** While `cs_n=0`, `rd_n=0` and `a!=3`, `dout_en=1`.
  - Source is `latch[a]` if `latched[a]`, else `cnt_val[a]`.
  - Byte is chosen by `RW`: `01` gives LSB, `10` gives MSB, `11` gives the `rptr[a]` byte.
  - `a=3` read: `dout_en=0`, `dout` holds its previous value.
  - The read-complete event fires on `rd_n` returning high. On that event:
    - `RW=11` toggles `rptr`.
    - `latched[a]` clears when the full value has been read: after 1 byte for `RW=01`/`10`, or after the MSB for `RW=11`.
- **Simultaneous write and read** (both strobes low): the write is taken and the read is ignored, with `dout_en=0`.

## Timing
- **Reset.** All of the following are 0 immediately on `rst`, independent of `clk`, and stay 0 until the first edge after `rst` deasserts:
  - `cw0`, `cw1`, `cw2`, `cw_load`, `count_wr`, `count_byte`, `count_hi`, `dout`, `dout_en`.
  - All pointers (LSB) and all `latched` flags.
- **Reset mid-strobe.** Asserting `rst` during a strobe discards the pending event. A strobe already low when `rst` deasserts is not recognised until it goes high and then low again.
- **Write latency.** With the write event detected at edge E, `cw_load`/`count_wr` are high for exactly the cycle after E. `cwN` updates at E.
- **Latch timing.** The latch copy of `cnt_val` is taken at edge E.
- **Read latency.** `dout` and `dout_en` are registered: valid one cycle after `rd_n`/`cs_n` low is sampled, and deasserted one cycle after `rd_n` high is sampled.
- **Strobe width.** The minimum strobe low width is 1 clk; back-to-back strobes need at least 1 high cycle.
- **At most one event per cycle.** Each pulse lasts exactly 1 cycle.
- **Pointer wrap.** Pointers wrap LSB→MSB→LSB with no limit.
- **Control word mid-sequence.** A new control word for counter n mid-sequence (after only the LSB was written or read) resets both of its pointers.

## Test plan
- **Reset and program counter 1.** After `rst`, write `a=3`, `din=8'h74` (SC=1, RW=11, M=2). Required: `cw1=6'h34` and `cw_load=3'b010` for 1 cycle; other `cw` outputs stay 0.
- **LSB-then-MSB write.** Write `a=1` with `8'h34`, then `8'h12`. Required: `count_wr[1]` pulses twice; `count_byte`/`count_hi` are `34`/0, then `12`/1.
- **Latch and read.**
  - Set up: `cnt_val[31:16]=16'hABCD`, then write `a=3`, `din=8'h40` (latch counter 1).
  - Change `cnt_val` to `16'h0000` and read `a=1` twice. Required: `dout` = `CD`, then `AB`.
  - Read a third time. Required: live `00`.
- **Double latch.** Issue a second latch before reading. Required: the original value is retained.
- **MSB-only counter.** Program counter 0 with `din=8'h20` (RW=10), then write `8'h55`. Required: `count_hi=1`. A read then returns `cnt_val[15:8]`.
- **Corner cases.**
  - Write to unprogrammed counter 2: no `count_wr` pulse.
  - `rd_n` and `wr_n` low together: write taken, `dout_en=0`.
  - `rst` asserted during `wr_n` low: no `cw_load` pulse after release.

Source files
------------

// File: rtl/i8254_bus_ctrl.sv
// Bus interface and command sequencer for a three-counter 8254 timer.
// Decodes CPU strobes into control-word loads, count-byte writes, latch commands and readback.
module i8254_bus_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [1:0]         a,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               dout_en,
  output logic [5:0]         cw0,
  output logic [5:0]         cw1,
  output logic [5:0]         cw2,
  output logic [2:0]         cw_load,
  output logic [7:0]         count_byte,
  output logic               count_hi,
  output logic [2:0]         count_wr,
  input  logic [3*CNT_W-1:0] cnt_val
);

  typedef enum logic {BYTE_LSB, BYTE_MSB} bytePtr_t;

  function automatic bytePtr_t flip(input bytePtr_t p);
    return (p == BYTE_LSB) ? BYTE_MSB : BYTE_LSB;
  endfunction

  logic [5:0]  cw [3];
  logic [15:0] latchVal [3];
  logic [15:0] liveCnt [3];
  logic [2:0]  latched;
  bytePtr_t    wptr [3];
  bytePtr_t    rptr [3];

  logic        wrArm, wrLow, rdArm, rdLow;
  logic [7:0]  wrData;
  logic [1:0]  wrAddr, rdAddr;

  logic        wrStrobe, rdStrobe, wrEvent, rdEvent;
  logic [1:0]  rdSel, wrSel, wrSc, wrRw, cntRw, doneRw;
  logic [15:0] rdSrc;
  logic [1:0]  rdRw;
  logic        rdHi;
  logic [7:0]  rdByte;

  assign cw0 = cw[0];
  assign cw1 = cw[1];
  assign cw2 = cw[2];

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      liveCnt[i] = cnt_val[i*CNT_W +: 16];
    end
  end

  // A read overlapped by a write is dropped entirely; the write wins.
  assign wrStrobe = !cs_n && !wr_n;
  assign rdStrobe = !cs_n && !rd_n && wr_n && (a != 2'd3);
  assign wrEvent  = wr_n && wrLow;
  assign rdEvent  = rd_n && rdLow;

  assign rdSel  = (a == 2'd3) ? 2'd0 : a;
  assign wrSel  = (wrAddr == 2'd3) ? 2'd0 : wrAddr;
  assign wrSc   = wrData[7:6];
  assign wrRw   = wrData[5:4];
  assign cntRw  = cw[wrSel][5:4];
  assign doneRw = cw[rdAddr][5:4];

  always_comb begin
    rdSrc  = latched[rdSel] ? latchVal[rdSel] : liveCnt[rdSel];
    rdRw   = cw[rdSel][5:4];
    rdHi   = (rdRw == 2'b10) || ((rdRw == 2'b11) && (rptr[rdSel] == BYTE_MSB));
    rdByte = rdHi ? rdSrc[15:8] : rdSrc[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        cw[i]       <= '0;
        latchVal[i] <= '0;
        wptr[i]     <= BYTE_LSB;
        rptr[i]     <= BYTE_LSB;
      end
      latched    <= '0;
      cw_load    <= '0;
      count_wr   <= '0;
      count_byte <= '0;
      count_hi   <= 1'b0;
      dout       <= '0;
      dout_en    <= 1'b0;
      wrArm      <= 1'b0;
      wrLow      <= 1'b0;
      wrData     <= '0;
      wrAddr     <= '0;
      rdArm      <= 1'b0;
      rdLow      <= 1'b0;
      rdAddr     <= '0;
    end else begin
      cw_load  <= '0;
      count_wr <= '0;

      // Strobes held low through reset stay ignored until seen high once.
      if (wr_n) wrArm <= 1'b1;
      if (rd_n) rdArm <= 1'b1;

      wrLow <= wrArm && wrStrobe;
      if (wrArm && wrStrobe) begin
        wrData <= din;
        wrAddr <= a;
      end

      rdLow   <= rdArm && rdStrobe;
      dout_en <= rdArm && rdStrobe;
      if (rdArm && rdStrobe) begin
        rdAddr <= a;
        dout   <= rdByte;
      end

      if (rdEvent) begin
        if (doneRw == 2'b11) begin
          rptr[rdAddr] <= flip(rptr[rdAddr]);
          if (rptr[rdAddr] == BYTE_MSB) latched[rdAddr] <= 1'b0;
        end else if (doneRw != 2'b00) begin
          latched[rdAddr] <= 1'b0;
        end
      end

      if (wrEvent) begin
        if (wrAddr == 2'd3) begin
          if (wrSc != 2'd3) begin
            if (wrRw == 2'b00) begin
              if (!latched[wrSc]) begin
                latchVal[wrSc] <= liveCnt[wrSc];
                latched[wrSc]  <= 1'b1;
              end
            end else begin
              cw[wrSc]      <= wrData[5:0];
              cw_load[wrSc] <= 1'b1;
              wptr[wrSc]    <= BYTE_LSB;
              rptr[wrSc]    <= BYTE_LSB;
              latched[wrSc] <= 1'b0;
            end
          end
        end else if (cntRw != 2'b00) begin
          count_wr[wrSel] <= 1'b1;
          count_byte      <= wrData;
          count_hi        <= (cntRw == 2'b10) || ((cntRw == 2'b11) && (wptr[wrSel] == BYTE_MSB));
          if (cntRw == 2'b11) wptr[wrSel] <= flip(wptr[wrSel]);
        end
      end
    end
  end

endmodule

// File: tb/tb_i8254_bus_ctrl.sv
// Self-checking bench for i8254_bus_ctrl: directed test-plan steps plus randomized
// bus transactions compared every cycle against a transaction-level model.
module tb_i8254_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [1:0]  a = '0;
  logic [7:0]  din = '0;
  logic [47:0] cntVal = '0;
  logic [7:0]  dout, count_byte;
  logic        dout_en, count_hi;
  logic [5:0]  cw0, cw1, cw2;
  logic [2:0]  cw_load, count_wr;

  i8254_bus_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a(a), .din(din),
    .dout(dout), .dout_en(dout_en), .cw0(cw0), .cw1(cw1), .cw2(cw2), .cw_load(cw_load),
    .count_byte(count_byte), .count_hi(count_hi), .count_wr(count_wr), .cnt_val(cntVal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  // Model state: per-counter control word, bytes written/read since programming, latch.
  logic [5:0]  mCw [3];
  int          wrCnt [3];
  int          rdCnt [3];
  bit          mLatched [3];
  logic [15:0] mLatch [3];
  logic [2:0]  expCwLoad = '0, expCountWr = '0;
  logic [7:0]  expCountByte = '0, expDout = '0;
  logic        expCountHi = 1'b0, expDoutEn = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] live(input int n);
    return cntVal[n*16 +: 16];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mCw[i] = '0; wrCnt[i] = 0; rdCnt[i] = 0; mLatched[i] = 0; mLatch[i] = '0;
    end
    expCwLoad = '0; expCountWr = '0; expCountByte = '0; expCountHi = 0;
    expDout = '0; expDoutEn = 0;
  endtask

  function automatic logic [7:0] modelByte(input int n);
    logic [15:0] src;
    logic [1:0] rw;
    bit hi;
    src = mLatched[n] ? mLatch[n] : live(n);
    rw = mCw[n][5:4];
    hi = (rw == 2'b10) || (rw == 2'b11 && (rdCnt[n] % 2) == 1);
    return hi ? src[15:8] : src[7:0];
  endfunction

  task automatic modelReadDone(input int n);
    logic [1:0] rw;
    rw = mCw[n][5:4];
    if (rw == 2'b11) begin
      rdCnt[n]++;
      if (rdCnt[n] % 2 == 0) mLatched[n] = 0;
    end else if (rw != 2'b00) begin
      mLatched[n] = 0;
    end
  endtask

  task automatic modelWrite(input logic [1:0] addr, input logic [7:0] data);
    int sc;
    logic [1:0] rw;
    if (addr == 2'd3) begin
      sc = int'(data[7:6]);
      if (sc != 3) begin
        if (data[5:4] == 2'b00) begin
          if (!mLatched[sc]) begin mLatch[sc] = live(sc); mLatched[sc] = 1; end
        end else begin
          mCw[sc] = data[5:0]; expCwLoad[sc] = 1'b1;
          wrCnt[sc] = 0; rdCnt[sc] = 0; mLatched[sc] = 0;
        end
      end
    end else begin
      rw = mCw[addr][5:4];
      if (rw != 2'b00) begin
        expCountWr[addr] = 1'b1;
        expCountByte = data;
        expCountHi = (rw == 2'b10) || (rw == 2'b11 && (wrCnt[addr] % 2) == 1);
        if (rw == 2'b11) wrCnt[addr]++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      check("cw0", 16'(cw0), 16'(mCw[0]));
      check("cw1", 16'(cw1), 16'(mCw[1]));
      check("cw2", 16'(cw2), 16'(mCw[2]));
      check("cw_load", 16'(cw_load), 16'(expCwLoad));
      check("count_wr", 16'(count_wr), 16'(expCountWr));
      check("count_byte", 16'(count_byte), 16'(expCountByte));
      check("count_hi", 16'(count_hi), 16'(expCountHi));
      check("dout_en", 16'(dout_en), 16'(expDoutEn));
      check("dout", 16'(dout), 16'(expDout));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Write (optionally with rd_n also low); din wanders while low, only the last value counts.
  task automatic doWrite(input logic [1:0] addr, input logic [7:0] data, input int lowCyc,
                         input bit withRd, output logic [2:0] gotLoad, output logic [2:0] gotWr,
                         output logic [7:0] gotByte, output logic gotHi, output logic gotEn);
    cs_n = 0; wr_n = 0; a = addr; rd_n = withRd ? 1'b0 : 1'b1;
    gotEn = 1'b0;
    for (int i = 0; i < lowCyc; i++) begin
      din = (i == lowCyc - 1) ? data : 8'($urandom);
      tick();
      #1 gotEn = gotEn | dout_en;
    end
    wr_n = 1; rd_n = 1; cs_n = 1; a = 2'($urandom); din = 8'($urandom);
    tick();
    modelWrite(addr, data);
    #1;
    gotLoad = cw_load; gotWr = count_wr; gotByte = count_byte; gotHi = count_hi;
    tick();
    expCwLoad = '0; expCountWr = '0;
  endtask

  task automatic doRead(input logic [1:0] addr, input int lowCyc, output logic [7:0] gotDout);
    logic [7:0] b;
    b = (addr != 2'd3) ? modelByte(int'(addr)) : 8'h00;
    cs_n = 0; rd_n = 0; a = addr;
    gotDout = '0;
    for (int i = 0; i < lowCyc; i++) begin
      tick();
      if (addr != 2'd3) begin expDoutEn = 1; expDout = b; end
      #1 if (i == 0) gotDout = dout;
    end
    rd_n = 1; cs_n = 1; a = 2'($urandom);
    tick();
    expDoutEn = 0;
    if (addr != 2'd3) modelReadDone(int'(addr));
  endtask

  logic [2:0] gl, gw;
  logic [7:0] gb, gd;
  logic gh, ge;

  initial begin
    modelReset();
    checkOn = 1'b1;
    tick(); tick();
    rst = 0;
    tick(); tick(); tick();
    check("reset_cw1", 16'(cw1), 16'h0000);
    check("reset_dout_en", 16'(dout_en), 16'h0000);

    // Program counter 1: SC=1 RW=11 M=2
    doWrite(2'd3, 8'h74, 1, 0, gl, gw, gb, gh, ge);
    check("prog_cw_load", 16'(gl), 16'h0002);
    check("prog_cw1", 16'(cw1), 16'h0034);
    check("prog_cw0", 16'(cw0), 16'h0000);

    doWrite(2'd1, 8'h34, 2, 0, gl, gw, gb, gh, ge);
    check("lsb_wr", 16'(gw), 16'h0002);
    check("lsb_byte", 16'({gb, 7'd0, gh}), 16'h3400);
    doWrite(2'd1, 8'h12, 1, 0, gl, gw, gb, gh, ge);
    check("msb_wr", 16'(gw), 16'h0002);
    check("msb_byte", 16'({gb, 7'd0, gh}), 16'h1201);

    // Latch counter 1, then a second latch that must be ignored
    cntVal[31:16] = 16'hABCD;
    doWrite(2'd3, 8'h40, 1, 0, gl, gw, gb, gh, ge);
    check("latch_no_load", 16'(gl), 16'h0000);
    cntVal[31:16] = 16'h1111;
    doWrite(2'd3, 8'h40, 1, 0, gl, gw, gb, gh, ge);
    cntVal[31:16] = 16'h0000;
    doRead(2'd1, 1, gd); check("latch_rd_lsb", 16'(gd), 16'h00CD);
    doRead(2'd1, 2, gd); check("latch_rd_msb", 16'(gd), 16'h00AB);
    doRead(2'd1, 1, gd); check("live_rd", 16'(gd), 16'h0000);

    // MSB-only counter 0
    doWrite(2'd3, 8'h20, 1, 0, gl, gw, gb, gh, ge);
    check("msbonly_cw0", 16'(cw0), 16'h0020);
    doWrite(2'd0, 8'h55, 1, 0, gl, gw, gb, gh, ge);
    check("msbonly_wr", 16'({5'd0, gw, gb}), 16'h0155);
    check("msbonly_hi", 16'(gh), 16'h0001);
    cntVal[15:0] = 16'h9A5B;
    doRead(2'd0, 1, gd); check("msbonly_rd", 16'(gd), 16'h009A);

    // Unprogrammed counter 2
    doWrite(2'd2, 8'h77, 1, 0, gl, gw, gb, gh, ge);
    check("unprog_wr", 16'(gw), 16'h0000);

    // Write and read together: SC=2 RW=11 M=3
    doWrite(2'd3, 8'hB6, 2, 1, gl, gw, gb, gh, ge);
    check("simul_dout_en", 16'(ge), 16'h0000);
    check("simul_load", 16'(gl), 16'h0004);

    // Reset while a control write is low
    cs_n = 0; wr_n = 0; a = 2'd3; din = 8'h96;
    tick();
    rst = 1; modelReset();
    #1 check("async_rst_cw2", 16'({cw0, cw1, cw2}), 16'h0000);
    tick(); rst = 0;
    tick(); tick();
    wr_n = 1; cs_n = 1;
    gl = '0;
    for (int i = 0; i < 3; i++) begin tick(); gl = gl | cw_load; end
    check("rst_mid_no_load", 16'(gl), 16'h0000);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      int r, n;
      logic [1:0] ad;
      r = $urandom_range(0, 9);
      ad = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 3);
      if (r <= 1) begin
        doWrite(2'd3, 8'($urandom), n, 0, gl, gw, gb, gh, ge);
      end else if (r <= 4) begin
        doWrite(2'($urandom_range(0, 2)), 8'($urandom), n, 0, gl, gw, gb, gh, ge);
      end else if (r <= 7) begin
        if (ad != 2'd3 && mCw[ad][5:4] == 2'b00) ad = 2'd3;
        doRead(ad, n, gd);
      end else if (r == 8) begin
        cntVal = {$urandom, $urandom};
        tick();
      end else begin
        doWrite(ad, 8'($urandom), n, 1, gl, gw, gb, gh, ge);
      end
    end

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
